// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes the asynchronous I2S pins into the clk domain,
// captures one SAMPLE_WIDTH-bit word per channel slot (MSB first, one-bit
// I2S delay after each word-select change), flags short slots and raises
// SAMPLE_VALID for VALID_HOLD cycles after every right-channel word.
module i2s_receiver #(
   parameter int unsigned SAMPLE_WIDTH = 24,
   parameter int unsigned VALID_HOLD   = 4
) (
   input  logic                    clk,
   input  logic                    RESET,
   input  logic                    i_BCLK,
   input  logic                    i_LRCLK,
   input  logic                    i_SD,
   output logic [SAMPLE_WIDTH-1:0] o_SAMPLE_L,
   output logic [SAMPLE_WIDTH-1:0] o_SAMPLE_R,
   output logic                    SAMPLE_VALID,
   output logic                    o_FRAME_ERR
);

   localparam int unsigned CNT_W  = $clog2(SAMPLE_WIDTH + 1);
   localparam int unsigned HOLD_W = (VALID_HOLD > 1) ? $clog2(VALID_HOLD) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SAMPLE_WIDTH - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(VALID_HOLD - 1);

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      SHIFT     = 2'd1,
      PAD       = 2'd2
   } state_t;

   state_t                  state;

   logic                    bclk_s1, bclk_s2, bclk_s3;
   logic                    lr_s1, lr_s2;
   logic                    sd_s1, sd_s2;

   logic                    lr_prev;
   logic                    lr_primed;
   logic                    chan_r;
   logic [CNT_W-1:0]        bit_cnt;
   logic [SAMPLE_WIDTH-2:0] shreg;
   logic                    r_done;
   logic [HOLD_W-1:0]       hold_cnt;

   logic                    bit_strobe;
   logic                    boundary;
   logic [SAMPLE_WIDTH-1:0] word_next;

   // Two-flop synchronizers on all pins plus a third BCLK flop for edge detect
   always_ff @(posedge clk) begin
      if (!RESET) begin
         bclk_s1 <= 1'b0;
         bclk_s2 <= 1'b0;
         bclk_s3 <= 1'b0;
         lr_s1   <= 1'b0;
         lr_s2   <= 1'b0;
         sd_s1   <= 1'b0;
         sd_s2   <= 1'b0;
      end else begin
         bclk_s1 <= i_BCLK;
         bclk_s2 <= bclk_s1;
         bclk_s3 <= bclk_s2;
         lr_s1   <= i_LRCLK;
         lr_s2   <= lr_s1;
         sd_s1   <= i_SD;
         sd_s2   <= sd_s1;
      end
   end

   // Bit strobe, slot-boundary detect and the next shift-register contents
   always_comb begin
      bit_strobe = bclk_s2 & ~bclk_s3;
      // lr_prev only means something once a strobe has loaded it after reset,
      // so a right-channel LRCLK at release is not mistaken for a boundary.
      boundary   = bit_strobe & lr_primed & (lr_s2 != lr_prev);
      word_next  = {shreg, sd_s2};
   end

   // Word-select history, updated on every bit strobe
   always_ff @(posedge clk) begin
      if (!RESET) begin
         lr_prev   <= 1'b0;
         lr_primed <= 1'b0;
      end else if (bit_strobe) begin
         lr_prev   <= lr_s2;
         lr_primed <= 1'b1;
      end
   end

   // Capture FSM: sync to first boundary, shift one word, pad to next boundary
   always_ff @(posedge clk) begin
      if (!RESET) begin
         state       <= WAIT_SYNC;
         bit_cnt     <= '0;
         shreg       <= '0;
         chan_r      <= 1'b0;
         o_SAMPLE_L  <= '0;
         o_SAMPLE_R  <= '0;
         o_FRAME_ERR <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         o_FRAME_ERR <= 1'b0;
         r_done      <= 1'b0;
         if (state != WAIT_SYNC && state != SHIFT && state != PAD) begin
            state <= WAIT_SYNC;
         end else if (boundary) begin
            // Boundary wins over word completion; the SD bit on this strobe
            // is the previous word's trailing bit and is dropped.
            if (state == SHIFT) begin
               o_FRAME_ERR <= 1'b1;
            end
            bit_cnt <= '0;
            chan_r  <= lr_s2;
            state   <= SHIFT;
         end else if (bit_strobe && state == SHIFT) begin
            shreg <= word_next[SAMPLE_WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
               bit_cnt <= '0;
               state   <= PAD;
               if (chan_r) begin
                  o_SAMPLE_R <= word_next;
                  r_done     <= 1'b1;
               end else begin
                  o_SAMPLE_L <= word_next;
               end
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
      end
   end

   // SAMPLE_VALID hold window, restarted by every new right-channel word
   always_ff @(posedge clk) begin
      if (!RESET) begin
         hold_cnt     <= '0;
         SAMPLE_VALID <= 1'b0;
      end else if (r_done) begin
         hold_cnt     <= HOLD_LOAD;
         SAMPLE_VALID <= 1'b1;
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - HOLD_W'(1);
      end else begin
         SAMPLE_VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2s_receiver.sv
// Testbench for i2s_receiver: drives I2S slots from a small bit-level model,
// pushes expected stereo words to a scoreboard as right words are driven and
// compares them (plus latency and hold length) when SAMPLE_VALID rises.
module tb_i2s_receiver;

   localparam int unsigned W     = 24;
   localparam int unsigned HOLD  = 4;
   localparam int unsigned W2    = 2;
   localparam int unsigned HOLD2 = 40;

   logic          clk = 1'b0;
   logic          RESET;
   logic          i_BCLK, i_LRCLK, i_SD;
   logic [W-1:0]  o_SAMPLE_L, o_SAMPLE_R;
   logic          SAMPLE_VALID, o_FRAME_ERR;

   logic          h_bclk, h_lrclk, h_sd;
   logic [W2-1:0] h_sample_l, h_sample_r;
   logic          h_valid, h_frame_err;

   i2s_receiver #(.SAMPLE_WIDTH(W), .VALID_HOLD(HOLD)) dut (
      .clk          (clk),
      .RESET        (RESET),
      .i_BCLK       (i_BCLK),
      .i_LRCLK      (i_LRCLK),
      .i_SD         (i_SD),
      .o_SAMPLE_L   (o_SAMPLE_L),
      .o_SAMPLE_R   (o_SAMPLE_R),
      .SAMPLE_VALID (SAMPLE_VALID),
      .o_FRAME_ERR  (o_FRAME_ERR)
   );

   i2s_receiver #(.SAMPLE_WIDTH(W2), .VALID_HOLD(HOLD2)) dut_h (
      .clk          (clk),
      .RESET        (RESET),
      .i_BCLK       (h_bclk),
      .i_LRCLK      (h_lrclk),
      .i_SD         (h_sd),
      .o_SAMPLE_L   (h_sample_l),
      .o_SAMPLE_R   (h_sample_r),
      .SAMPLE_VALID (h_valid),
      .o_FRAME_ERR  (h_frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] l;
      logic [W-1:0] r;
      int           edge_no;
   } exp_t;

   exp_t         sb_q[$];

   int           tests = 0;
   int           fails = 0;
   int           edge_cnt = 0;
   int           err_seen = 0;
   int           err_exp = 0;
   int           h_err_seen = 0;
   int           h_rises = 0;
   int           h_falls = 0;
   int           h_fall_edge = 0;
   int           hi_ph = 3;
   int           lo_ph = 3;

   logic [W-1:0] m_l, m_r;
   bit           m_synced, m_shift;

   logic         v_prev, h_prev;
   int           v_len = 0;
   logic [W-1:0] r_hold, l_hold;
   exp_t         e_mon;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One BCLK period: data/word-select change in the low phase, rise after it
   task automatic drive_bit(input bit sel, input logic lr, input logic sd);
      if (!sel) begin
         i_BCLK = 1'b0; i_LRCLK = lr; i_SD = sd;
      end else begin
         h_bclk = 1'b0; h_lrclk = lr; h_sd = sd;
      end
      repeat (lo_ph) @(negedge clk);
      if (!sel) i_BCLK = 1'b1;
      else      h_bclk = 1'b1;
      repeat (hi_ph) @(negedge clk);
   endtask

   task automatic idle(input int n);
      i_BCLK = 1'b0;
      h_bclk = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_partial(input logic lr, input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b0, lr, 1'($urandom_range(1, 0)));
   endtask

   // Slot = boundary bit (dropped) + ndata word bits MSB first + npad filler
   task automatic drive_slot(input logic lr, input logic [W-1:0] word,
                             input int ndata, input int npad);
      exp_t e;
      if (m_synced && m_shift) err_exp++;
      m_synced = 1'b1;
      m_shift  = 1'b1;
      drive_bit(1'b0, lr, 1'($urandom_range(1, 0)));
      for (int i = 0; i < ndata; i++) begin
         if (i == int'(W) - 1) begin
            m_shift = 1'b0;
            if (lr) begin
               m_r       = word;
               e.l       = m_l;
               e.r       = m_r;
               e.edge_no = edge_cnt + lo_ph;
               sb_q.push_back(e);
            end else begin
               m_l = word;
            end
         end
         drive_bit(1'b0, lr, word[int'(W) - 1 - i]);
      end
      for (int i = 0; i < npad; i++) drive_bit(1'b0, lr, 1'($urandom_range(1, 0)));
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      RESET  = 1'b0;
      i_BCLK = 1'b0;
      h_bclk = 1'b0;
      repeat (n) @(negedge clk);
      check("rst_sample_l", o_SAMPLE_L, 0);
      check("rst_sample_r", o_SAMPLE_R, 0);
      check("rst_valid", SAMPLE_VALID, 0);
      check("rst_frame_err", o_FRAME_ERR, 0);
      check("rst_h_sample_r", h_sample_r, 0);
      check("rst_h_valid", h_valid, 0);
      RESET    = 1'b1;
      m_l      = '0;
      m_r      = '0;
      m_synced = 1'b0;
      m_shift  = 1'b0;
   endtask

   // Output monitor, sampling 1 time unit after each rising clk edge
   initial begin
      v_prev = 1'b0;
      h_prev = 1'b0;
      forever begin
         @(posedge clk);
         edge_cnt++;
         #1;
         if (SAMPLE_VALID === 1'b1 && v_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
               check("valid_unexpected", sb_q.size(), 1);
            end else begin
               e_mon = sb_q.pop_front();
               check("sample_l", o_SAMPLE_L, e_mon.l);
               check("sample_r", o_SAMPLE_R, e_mon.r);
               check("latency", edge_cnt - e_mon.edge_no, 4);
            end
            v_len  = 1;
            r_hold = o_SAMPLE_R;
            l_hold = o_SAMPLE_L;
         end else if (SAMPLE_VALID === 1'b1) begin
            v_len++;
         end else if (v_prev === 1'b1) begin
            check("valid_len", v_len, HOLD);
            check("hold_stable_r", o_SAMPLE_R, r_hold);
            check("hold_stable_l", o_SAMPLE_L, l_hold);
         end
         v_prev = SAMPLE_VALID;
         if (o_FRAME_ERR === 1'b1) err_seen++;
         if (h_frame_err === 1'b1) h_err_seen++;
         if (h_valid === 1'b1 && h_prev !== 1'b1) h_rises++;
         if (h_valid === 1'b0 && h_prev === 1'b1) begin
            h_falls++;
            h_fall_edge = edge_cnt;
         end
         h_prev = h_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W2-1:0] lw, rw;
      int            last_r_edge;

      RESET = 1'b0;
      i_BCLK = 1'b0; i_LRCLK = 1'b0; i_SD = 1'b0;
      h_bclk = 1'b0; h_lrclk = 1'b0; h_sd = 1'b0;

      // 64-BCLK frames of 32-bit slots, BCLK = 9 clk periods (5 low, 4 high)
      lo_ph = 5; hi_ph = 4;
      do_reset(4);
      drive_partial(1'b1, 5);
      for (int f = 0; f < 2; f++) begin
         drive_slot(1'b0, 24'hA5A5A5, 24, 7);
         drive_slot(1'b1, 24'h123456, 24, 7);
      end
      drive_slot(1'b0, 24'h5A5A5A, 24, 7);
      drive_slot(1'b1, 24'hABCDEF, 24, 7);
      idle(30);
      check("a_frame_err", err_seen, err_exp);
      check("a_drained", sb_q.size(), 0);
      check("a_final_r", o_SAMPLE_R, m_r);

      // Slots of boundary + exactly 24 bits: completion just before boundary
      lo_ph = 3; hi_ph = 3;
      drive_slot(1'b0, 24'hC3C3C3, 24, 0);
      drive_slot(1'b1, 24'hFFFFFF, 24, 0);
      drive_slot(1'b0, 24'h3C3C3C, 24, 0);
      drive_slot(1'b1, 24'h000001, 24, 0);
      idle(30);
      check("b_frame_err", err_seen, err_exp);
      check("b_final_r", o_SAMPLE_R, 24'h000001);
      // 48-BCLK frames: the 24th bit lands on the boundary strobe -> short
      drive_slot(1'b0, 24'h111111, 23, 0);
      drive_slot(1'b1, 24'h222222, 23, 0);
      drive_slot(1'b0, 24'hA5A5A5, 24, 7);
      check("b48_frame_err", err_seen, err_exp);
      check("b48_r_kept", o_SAMPLE_R, 24'h000001);
      drive_slot(1'b1, 24'h123456, 24, 7);
      idle(30);
      check("b_drained", sb_q.size(), 0);

      // Short right slot (16 BCLK) between full left slots
      drive_slot(1'b0, 24'h0ABCDE, 24, 7);
      drive_slot(1'b1, 24'h777777, 15, 0);
      drive_slot(1'b0, 24'h13579B, 24, 7);
      check("c_short_err", err_seen, err_exp);
      check("c_r_kept", o_SAMPLE_R, 24'h123456);
      drive_slot(1'b1, 24'h654321, 24, 7);
      idle(30);
      check("c_frame_err", err_seen, err_exp);
      check("c_drained", sb_q.size(), 0);

      // Reset mid left word, release mid left slot
      drive_slot(1'b0, 24'h2468AC, 10, 0);
      do_reset(3);
      drive_partial(1'b0, 14);
      drive_slot(1'b1, 24'h0F1E2D, 24, 7);
      drive_slot(1'b0, 24'h3C4B5A, 24, 7);
      drive_slot(1'b1, 24'h698778, 24, 7);
      idle(30);
      check("d_frame_err", err_seen, err_exp);
      check("d_drained", sb_q.size(), 0);

      // VALID_HOLD = 40 instance: 36-clk frames keep SAMPLE_VALID high
      lo_ph = 3; hi_ph = 3;
      last_r_edge = 0;
      lw = '0;
      rw = '0;
      drive_bit(1'b1, 1'b1, 1'b0);
      drive_bit(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) begin
         lw = 2'(k);
         rw = 2'(k + 1);
         drive_bit(1'b1, 1'b0, 1'($urandom_range(1, 0)));
         drive_bit(1'b1, 1'b0, lw[1]);
         drive_bit(1'b1, 1'b0, lw[0]);
         drive_bit(1'b1, 1'b1, 1'($urandom_range(1, 0)));
         drive_bit(1'b1, 1'b1, rw[1]);
         last_r_edge = edge_cnt + lo_ph;
         drive_bit(1'b1, 1'b1, rw[0]);
      end
      idle(80);
      check("h_rises", h_rises, 1);
      check("h_falls", h_falls, 1);
      check("h_last_to_fall", h_fall_edge - last_r_edge, 4 + HOLD2);
      check("h_sample_l", h_sample_l, lw);
      check("h_sample_r", h_sample_r, rw);
      check("h_frame_err", h_err_seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
